// File: rtl/sram_array.sv
`default_nettype none
// ============================================================================
// Module   : sram_array
// Brief    : WIDTH x DEPTH synchronous single-port memory with a registered
//            read output, a one-cycle read-valid pulse and a hardware clear
//            sequence that zeroes every word after reset.
// Revision : 1.0 - initial release
// ============================================================================
module sram_array #(
    parameter int WIDTH  = 4,
    parameter int DEPTH  = 16,
    parameter int ADDR_W = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              sel,
    input  logic              rw,
    input  logic [ADDR_W-1:0] addr,
    input  logic [WIDTH-1:0]  data,
    output logic [WIDTH-1:0]  out,
    output logic              valid,
    output logic              busy
);

    // Last word touched by the clear sequence, and the depth widened by one
    // bit so the range check stays meaningful when DEPTH == 2**ADDR_W.
    localparam logic [ADDR_W-1:0] c_LAST  = ADDR_W'(DEPTH - 1);
    localparam logic [ADDR_W:0]   c_DEPTH = (ADDR_W + 1)'(DEPTH);

    typedef enum logic [0:0] {
        CLEAR = 1'b0,
        READY = 1'b1
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [ADDR_W-1:0]   r_ptr;
    logic [ADDR_W-1:0]   w_ptr_nxt;
    logic [WIDTH-1:0]    r_mem [DEPTH];

    logic                w_in_range;
    logic                w_mem_we;
    logic [ADDR_W-1:0]   w_mem_addr;
    logic [WIDTH-1:0]    w_mem_wdata;
    logic                w_rd_en;

    // Out-of-range addresses never touch storage, so no aliasing can occur.
    assign w_in_range = ({1'b0, addr} < c_DEPTH);
    assign busy       = (r_state == CLEAR);

    // State and clear-pointer register; reset restarts the clear from word 0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= CLEAR;
            r_ptr   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_ptr   <= w_ptr_nxt;
        end
    end

    // Next state plus the single memory write port, shared by clear and user writes.
    always_comb begin
        w_state_nxt = r_state;
        w_ptr_nxt   = r_ptr;
        w_mem_we    = 1'b0;
        w_mem_addr  = addr;
        w_mem_wdata = data;
        w_rd_en     = 1'b0;
        case (r_state)
            CLEAR: begin
                w_mem_we    = 1'b1;
                w_mem_addr  = r_ptr;
                w_mem_wdata = '0;
                w_ptr_nxt   = r_ptr + ADDR_W'(1);
                if (r_ptr == c_LAST) begin
                    w_state_nxt = READY;
                end
            end
            READY: begin
                // Only a definite sel=1 opens an access; X/Z falls to the idle branch.
                if (sel && rw && w_in_range) begin
                    w_mem_we = 1'b1;
                end
                if (sel && !rw) begin
                    w_rd_en = 1'b1;
                end
            end
            default: begin
                w_state_nxt = CLEAR;
                w_ptr_nxt   = '0;
            end
        endcase
    end

    // Storage has no reset; it is zeroed by the clear sequence instead.
    always_ff @(posedge clk) begin
        if (w_mem_we) begin
            r_mem[w_mem_addr] <= w_mem_wdata;
        end
    end

    // Registered read port: out holds between reads, valid pulses per read.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out   <= '0;
            valid <= 1'b0;
        end else begin
            valid <= w_rd_en;
            if (w_rd_en) begin
                out <= w_in_range ? r_mem[addr] : '0;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_sram_array.sv
`default_nettype none
// ============================================================================
// Module   : tb_sram_array
// Brief    : Directed, table-driven self-checking bench for sram_array
//            (default 16-word instance plus a 12-word instance).
// Revision : 1.0 - initial release
// ============================================================================
module tb_sram_array;

    logic       clk;
    logic       rst_n;
    logic       sel, rw;
    logic [3:0] addr, data;
    logic [3:0] out;
    logic       valid, busy;

    logic       sel12, rw12;
    logic [3:0] addr12, data12;
    logic [3:0] out12;
    logic       valid12, busy12;

    int checks = 0;
    int errors = 0;

    sram_array #(.WIDTH(4), .DEPTH(16), .ADDR_W(4)) dut (
        .clk(clk), .rst_n(rst_n), .sel(sel), .rw(rw), .addr(addr), .data(data),
        .out(out), .valid(valid), .busy(busy)
    );

    sram_array #(.WIDTH(4), .DEPTH(12), .ADDR_W(4)) dut12 (
        .clk(clk), .rst_n(rst_n), .sel(sel12), .rw(rw12), .addr(addr12), .data(data12),
        .out(out12), .valid(valid12), .busy(busy12)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       sel;
        logic       rw;
        logic [3:0] addr;
        logic [3:0] data;
        logic [3:0] eout;
        logic       evalid;
    } vec_t;

    vec_t vq[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic void add(input logic s, input logic r, input logic [3:0] a,
                                input logic [3:0] d, input logic [3:0] eo, input logic ev);
        vec_t v;
        v.sel = s; v.rw = r; v.addr = a; v.data = d; v.eout = eo; v.evalid = ev;
        vq.push_back(v);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drive one 12-word-instance access and check the outputs after the edge.
    task automatic d12(input string name, input logic s, input logic r, input logic [3:0] a,
                       input logic [3:0] d, input logic [3:0] eo, input logic ev);
        sel12 = s; rw12 = r; addr12 = a; data12 = d;
        tick();
        chk({name, "_out"}, {28'd0, out12}, {28'd0, eo});
        chk({name, "_valid"}, {31'd0, valid12}, {31'd0, ev});
        sel12 = 1'b0;
    endtask

    // Release reset and require busy high for exactly 16 edges.
    task automatic clear_count(input string name);
        rst_n = 1'b1;
        for (int k = 1; k <= 16; k++) begin
            tick();
            chk({name, "_busy"}, {31'd0, busy}, (k >= 16) ? 32'd0 : 32'd1);
            chk({name, "_valid"}, {31'd0, valid}, 32'd0);
        end
    endtask

    initial begin
        rst_n = 1'b0;
        sel = 1'b0; rw = 1'b0; addr = 4'd0; data = 4'd0;
        sel12 = 1'b0; rw12 = 1'b0; addr12 = 4'd0; data12 = 4'd0;
        tick();
        tick();
        chk("rst_busy",  {31'd0, busy},  32'd1);
        chk("rst_out",   {28'd0, out},   32'd0);
        chk("rst_valid", {31'd0, valid}, 32'd0);

        // Clear period, with a write attempt held on the port the whole time.
        sel = 1'b1; rw = 1'b1; addr = 4'd5; data = 4'hF;
        rst_n = 1'b1;
        for (int k = 1; k <= 16; k++) begin
            tick();
            chk("clr_busy",   {31'd0, busy},   (k >= 16) ? 32'd0 : 32'd1);
            chk("clr_out",    {28'd0, out},    32'd0);
            chk("clr_valid",  {31'd0, valid},  32'd0);
            chk("clr12_busy", {31'd0, busy12}, (k >= 12) ? 32'd0 : 32'd1);
        end

        // Directed vector table: each row's expectations hold after its edge.
        for (int i = 0; i < 16; i++) add(1, 0, 4'(i), 4'hF, 4'h0, 1);
        add(1, 1, 4'd3, 4'hA, 4'h0, 0);
        add(1, 0, 4'd3, 4'h0, 4'hA, 1);
        for (int i = 0; i < 10; i++) add(0, 0, 4'(i), 4'(15 - i), 4'hA, 0);
        add(1, 1, 4'd7, 4'hF, 4'hA, 0);
        add(1, 1, 4'd7, 4'h0, 4'hA, 0);
        add(1, 0, 4'd7, 4'hF, 4'h0, 1);
        for (int i = 0; i < 16; i++) add(1, 1, 4'(i), 4'(i), 4'h0, 0);
        for (int i = 15; i >= 0; i--) add(1, 0, 4'(i), 4'h0, 4'(i), 1);
        add(1, 1, 4'd2, 4'hC, 4'h0, 0);
        add(1, 0, 4'd2, 4'h0, 4'hC, 1);
        add(1, 1, 4'd9, 4'h5, 4'hC, 0);
        add(1, 0, 4'd9, 4'h0, 4'h5, 1);
        add(0, 1, 4'd4, 4'hF, 4'h5, 0);
        add(1, 0, 4'd4, 4'h0, 4'h4, 1);

        foreach (vq[i]) begin
            sel = vq[i].sel; rw = vq[i].rw; addr = vq[i].addr; data = vq[i].data;
            tick();
            chk($sformatf("vec%0d_out", i), {28'd0, out}, {28'd0, vq[i].eout});
            chk($sformatf("vec%0d_valid", i), {31'd0, valid}, {31'd0, vq[i].evalid});
        end
        sel = 1'b0;

        // 12-word instance: out-of-range write dropped without aliasing.
        d12("d12_wr1",  1, 1, 4'd1,  4'h6, 4'h0, 0);
        d12("d12_wr13", 1, 1, 4'd13, 4'h9, 4'h0, 0);
        d12("d12_rd13", 1, 0, 4'd13, 4'h0, 4'h0, 1);
        d12("d12_rd1",  1, 0, 4'd1,  4'h0, 4'h6, 1);
        d12("d12_rd13b", 1, 0, 4'd13, 4'h0, 4'h0, 1);
        d12("d12_rd11", 1, 0, 4'd11, 4'h0, 4'h0, 1);

        // Reset between a read request and the next edge.
        sel = 1'b1; rw = 1'b1; addr = 4'd6; data = 4'hD;
        tick();
        rw = 1'b0; data = 4'h0;
        tick();
        chk("pre_rst_out",   {28'd0, out},   32'hD);
        chk("pre_rst_valid", {31'd0, valid}, 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_rst_out",   {28'd0, out},   32'd0);
        chk("async_rst_valid", {31'd0, valid}, 32'd0);
        chk("async_rst_busy",  {31'd0, busy},  32'd1);
        sel = 1'b0;
        tick();
        clear_count("clr2");
        sel = 1'b1; rw = 1'b0; addr = 4'd6;
        tick();
        chk("post_clr_rd6", {28'd0, out}, 32'd0);
        chk("post_clr_rd6_valid", {31'd0, valid}, 32'd1);
        addr = 4'd15;
        tick();
        chk("post_clr_rd15", {28'd0, out}, 32'd0);
        sel = 1'b0;

        // Reset asserted partway through clear restarts the full count.
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        for (int k = 1; k <= 5; k++) tick();
        chk("mid_clr_busy", {31'd0, busy}, 32'd1);
        rst_n = 1'b0;
        tick();
        clear_count("clr3");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Absolute time bound in case anything above stalls.
    initial begin
        #200000;
        $display("FAIL timeout actual=running required=finished");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire

// File: doc/sram_array.md
Name: sram_array

Overview:
Parametrised synchronous memory array. It is the clocked, multi-word successor to the single SR-latch bitcell, and keeps the same sel/rw/data/out port semantics. A word-addressed array of WIDTH x DEPTH storage sits behind a single shared read/write port, with a registered read output and a hardware clear sequence after reset. It serves as the storage block for the register-file and memory sections of the design.

Parameters:
WIDTH, 4, data word width in bits (>=1)
DEPTH, 16, number of words (>=2; need not be a power of two)
ADDR_W, 4, address width; must satisfy 2**ADDR_W >= DEPTH

Ports:
clk  input  1  system clock; all state changes on the rising edge
rst_n  input  1  asynchronous, active-low reset
sel  input  1  cell/array select; 1 = access enabled
rw  input  1  1 = write, 0 = read (sampled only when sel=1)
addr  input  ADDR_W  word address
data  input  WIDTH  write data
out  output  WIDTH  registered read data; holds the last value read
valid  output  1  one-cycle pulse: out was updated by a read this cycle
busy  output  1  1 while the post-reset clear sequence runs; accesses are ignored

Behaviour:
- Reset (rst_n=0, asynchronous, takes effect immediately):
  - out=0, valid=0, busy=1.
  - FSM enters CLEAR with clear pointer = 0.
  - Storage is not reset asynchronously; it is zeroed by the CLEAR sequence.
- FSM states: CLEAR, READY.
  - CLEAR: each cycle writes 0 to mem[ptr], then ptr <= ptr+1.
  - On the cycle that writes mem[DEPTH-1]: next state is READY and busy falls at that same edge.
  - Clear takes exactly DEPTH cycles after rst_n deasserts.
  - sel/rw/addr/data are ignored in CLEAR. valid stays 0 and out stays 0.
- READY, sel=1, rw=1 (write):
  - mem[addr] <= data at the rising edge.
  - out unchanged, valid=0 next cycle.
- READY, sel=1, rw=0 (read):
  - out <= mem[addr] at the rising edge (1-cycle latency).
  - valid=1 for that following cycle only.
  - Back-to-back reads give valid=1 every cycle.
- READY, sel=0:
  - No access. out holds its last value indefinitely; valid=0.
  - Stored contents are retained.
- Write then read of the same address on the next cycle returns the new data; the write commits at the edge before the read samples.
- Single port, so reads and writes never happen in the same cycle. Toggling rw every cycle is legal.
- Out-of-range addr (addr >= DEPTH):
  - Write is dropped; no other word is modified and no aliasing occurs.
  - Read sets out=0 with valid=1.
- Reset asserted mid-CLEAR or mid-access:
  - Outputs return to reset values immediately.
  - CLEAR restarts from ptr=0 after release.
  - Any write in flight at that edge is lost.
- data is don't-care on reads; addr and data are don't-care when sel=0.
- X/Z on sel or rw in READY must not corrupt storage. The bench checks this for sel=0.

Test Plan:
- Reset, then release: busy=1 for exactly DEPTH=16 cycles, then 0. A read of every address 0..15 returns out=0 with valid=1 one cycle after each request.
- Write 4'hA to addr 3, then read addr 3 on the next cycle -> out=4'hA with valid=1 exactly one cycle after the read request. Then sel=0 for 10 cycles -> out stays 4'hA and valid=0.
- Write 4'h0 over 4'hF at addr 7, then read with data=4'hF applied -> out=4'h0. This confirms the data input does not disturb a read.
- Write addr i <= i for i=0..15, then read back in reverse order -> each out=i, valid pulsing every cycle. With DEPTH=12 and ADDR_W=4, writing addr 13 -> the write is dropped, a read of addr 13 gives out=0, and addr 1 is unchanged.
- Assert sel=1, rw=1 during busy -> no write lands (location reads 0 after clear). Assert rst_n=0 at clear cycle 5 -> busy remains 1 for a full 16 cycles after release.
- Pull rst_n low between a read request and the next edge -> out=0 and valid=0 immediately. Stored data is zeroed by the subsequent clear.
